// File: rtl/risk_seq_if.sv
// Descriptor handshake bundle between a command source and the risk sequencer.
// The master drives descriptors; the sequencer (slave) returns cmd_ready.
interface risk_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_func;
    logic [4:0]  cmd_reg;
    logic [14:0] cmd_addr;
    logic [13:0] cmd_stride_x;
    logic [13:0] cmd_stride_y;
    logic [14:0] cmd_step;
    logic [7:0]  cmd_count;

    modport master (
        output cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
               cmd_step, cmd_count,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_func, cmd_reg, cmd_addr, cmd_stride_x, cmd_stride_y,
               cmd_step, cmd_count,
        output cmd_ready
    );
endinterface

// File: rtl/risk_seq.sv
// Expands one descriptor into a train of per-cycle risk-unit ops, then drains and pulses done.
// Optional macro RISK_SEQ_BOUNDS_EN rejects descriptors whose last address exceeds 15 bits.
module risk_seq #(
    parameter int DRAIN = 3
) (
    input  logic        clk,
    input  logic        reset,
    risk_seq_if.slave   cmd,
    output logic [2:0]  risk_func,
    output logic [4:0]  risk_reg,
    output logic [14:0] risk_addr,
    output logic [13:0] risk_stride_x,
    output logic [13:0] risk_stride_y,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam logic [2:0] FUNC_NOP = 3'b111;
    localparam int         DW       = $clog2(DRAIN + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [2:0]     func_reg, func_next;
    logic [4:0]     reg_cur_reg, reg_cur_next;
    logic [14:0]    addr_cur_reg, addr_cur_next;
    logic [14:0]    step_reg, step_next;
    logic [13:0]    sx_reg, sx_next;
    logic [13:0]    sy_reg, sy_next;
    logic [7:0]     remain_reg, remain_next;
    logic [DW-1:0]  drain_reg, drain_next;
    logic           err_reg, err_next;

    logic [2:0]     risk_func_reg, risk_func_next;
    logic [4:0]     risk_reg_reg, risk_reg_next;
    logic [14:0]    risk_addr_reg, risk_addr_next;
    logic [13:0]    risk_sx_reg, risk_sx_next;
    logic [13:0]    risk_sy_reg, risk_sy_next;

    logic           ready;
    logic           handshake;
    logic           reject_func;
    logic           reject_bounds;

    assign ready         = (state_reg == ST_IDLE) && !reset;
    assign cmd.cmd_ready = ready;
    assign handshake     = cmd.cmd_valid && ready;
    assign reject_func   = (cmd.cmd_func > 3'b010);

`ifdef RISK_SEQ_BOUNDS_EN
    logic [31:0] last_addr_full;
    assign last_addr_full = 32'(cmd.cmd_addr)
                          + (32'(cmd.cmd_count) - 32'd1) * 32'(cmd.cmd_step);
    assign reject_bounds  = (cmd.cmd_count != 8'd0) && (last_addr_full > 32'd32767);
`else
    assign reject_bounds  = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        func_next      = func_reg;
        reg_cur_next   = reg_cur_reg;
        addr_cur_next  = addr_cur_reg;
        step_next      = step_reg;
        sx_next        = sx_reg;
        sy_next        = sy_reg;
        remain_next    = remain_reg;
        drain_next     = drain_reg;
        err_next       = err_reg;
        risk_func_next = FUNC_NOP;
        risk_reg_next  = risk_reg_reg;
        risk_addr_next = risk_addr_reg;
        risk_sx_next   = risk_sx_reg;
        risk_sy_next   = risk_sy_reg;

        unique case (state_reg)
            ST_IDLE: begin
                if (handshake) begin
                    func_next     = cmd.cmd_func;
                    reg_cur_next  = cmd.cmd_reg;
                    addr_cur_next = cmd.cmd_addr;
                    step_next     = cmd.cmd_step;
                    sx_next       = cmd.cmd_stride_x;
                    sy_next       = cmd.cmd_stride_y;
                    remain_next   = cmd.cmd_count;
                    err_next      = reject_func || reject_bounds;
                    if (reject_func || reject_bounds || (cmd.cmd_count == 8'd0))
                        state_next = ST_FIN;
                    else
                        state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // The op computed here is registered and shows on risk_* next cycle.
                risk_func_next = func_reg;
                risk_reg_next  = reg_cur_reg;
                risk_addr_next = addr_cur_reg;
                risk_sx_next   = sx_reg;
                risk_sy_next   = sy_reg;
                reg_cur_next   = reg_cur_reg + 5'd1;
                addr_cur_next  = addr_cur_reg + step_reg;
                remain_next    = remain_reg - 8'd1;
                if (remain_reg == 8'd1) begin
                    state_next = ST_DRAIN;
                    drain_next = DW'(DRAIN);
                end
            end
            ST_DRAIN: begin
                // First DRAIN cycle still shows the final op; the rest are NOP cycles.
                if (drain_reg == '0)
                    state_next = ST_FIN;
                else
                    drain_next = drain_reg - DW'(1);
            end
            ST_FIN: begin
                state_next = ST_IDLE;
                err_next   = 1'b0;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            func_reg      <= 3'd0;
            reg_cur_reg   <= 5'd0;
            addr_cur_reg  <= 15'd0;
            step_reg      <= 15'd0;
            sx_reg        <= 14'd0;
            sy_reg        <= 14'd0;
            remain_reg    <= 8'd0;
            drain_reg     <= '0;
            err_reg       <= 1'b0;
            risk_func_reg <= FUNC_NOP;
            risk_reg_reg  <= 5'd0;
            risk_addr_reg <= 15'd0;
            risk_sx_reg   <= 14'd0;
            risk_sy_reg   <= 14'd0;
        end else begin
            state_reg     <= state_next;
            func_reg      <= func_next;
            reg_cur_reg   <= reg_cur_next;
            addr_cur_reg  <= addr_cur_next;
            step_reg      <= step_next;
            sx_reg        <= sx_next;
            sy_reg        <= sy_next;
            remain_reg    <= remain_next;
            drain_reg     <= drain_next;
            err_reg       <= err_next;
            risk_func_reg <= risk_func_next;
            risk_reg_reg  <= risk_reg_next;
            risk_addr_reg <= risk_addr_next;
            risk_sx_reg   <= risk_sx_next;
            risk_sy_reg   <= risk_sy_next;
        end
    end

    assign risk_func     = risk_func_reg;
    assign risk_reg      = risk_reg_reg;
    assign risk_addr     = risk_addr_reg;
    assign risk_stride_x = risk_sx_reg;
    assign risk_stride_y = risk_sy_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_FIN);
    assign err           = (state_reg == ST_FIN) && err_reg;
endmodule

// File: tb/tb_risk_seq.sv
// Directed and randomized descriptors against a cycle-indexed reference of the risk sequencer.
// Expected traces are derived from descriptor arithmetic, not from the sequencer's internals.
module tb_risk_seq;
    localparam int DRAIN = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  risk_func;
    logic [4:0]  risk_reg;
    logic [14:0] risk_addr;
    logic [13:0] risk_stride_x;
    logic [13:0] risk_stride_y;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Last op values the risk unit should still be seeing.
    logic [14:0] m_addr;
    logic [4:0]  m_reg;
    logic [13:0] m_sx;
    logic [13:0] m_sy;

    risk_seq_if cmd_if ();

    risk_seq #(.DRAIN(DRAIN)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd           (cmd_if.slave),
        .risk_func     (risk_func),
        .risk_reg      (risk_reg),
        .risk_addr     (risk_addr),
        .risk_stride_x (risk_stride_x),
        .risk_stride_y (risk_stride_y),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic scramble(input logic v);
        cmd_if.cmd_valid    = v;
        cmd_if.cmd_func     = 3'($urandom);
        cmd_if.cmd_reg      = 5'($urandom);
        cmd_if.cmd_addr     = 15'($urandom);
        cmd_if.cmd_stride_x = 14'($urandom);
        cmd_if.cmd_stride_y = 14'($urandom);
        cmd_if.cmd_step     = 15'($urandom);
        cmd_if.cmd_count    = 8'($urandom);
    endtask

    // Called at a falling edge with the sequencer idle. abort_c > 0 pulses reset in that cycle.
    task automatic run_desc(input string tag, input logic [2:0] f, input logic [4:0] r,
                            input logic [14:0] a, input logic [13:0] sx, input logic [13:0] sy,
                            input logic [14:0] st, input logic [7:0] cnt, input int abort_c);
        int          n_ops;
        int          done_c;
        logic        err_exp;
        logic        bad_func;
        logic        bad_bounds;
        logic [31:0] full;
        logic [31:0] lin;
        logic        op;
        bad_func = (f > 3'd2);
`ifdef RISK_SEQ_BOUNDS_EN
        full       = 32'(a) + (32'(cnt) - 32'd1) * 32'(st);
        bad_bounds = (cnt != 8'd0) && (full > 32'd32767);
`else
        full       = 32'd0;
        bad_bounds = 1'b0;
`endif
        if (bad_func || bad_bounds || cnt == 8'd0) begin
            n_ops = 0; done_c = 1; err_exp = bad_func || bad_bounds;
        end else begin
            n_ops = int'(cnt); done_c = int'(cnt) + DRAIN + 2; err_exp = 1'b0;
        end
        $display("txn %s func=%0d reg=%0d addr=%0d step=%0d count=%0d ops=%0d done_at=%0d err=%0b full=%0d",
                 tag, f, r, a, st, cnt, n_ops, done_c, err_exp, full);

        chk({tag, ".ready_pre"}, 32'(cmd_if.cmd_ready), 32'd1);
        cmd_if.cmd_valid    = 1'b1;
        cmd_if.cmd_func     = f;
        cmd_if.cmd_reg      = r;
        cmd_if.cmd_addr     = a;
        cmd_if.cmd_stride_x = sx;
        cmd_if.cmd_stride_y = sy;
        cmd_if.cmd_step     = st;
        cmd_if.cmd_count    = cnt;
        @(negedge clk);
        for (int c = 1; c <= done_c + 1; c++) begin
            op = (c >= 2) && (c <= n_ops + 1);
            if (op) begin
                lin    = 32'(a) + 32'(c - 2) * 32'(st);
                m_addr = lin[14:0];
                m_reg  = 5'(32'(r) + 32'(c - 2));
                m_sx   = sx;
                m_sy   = sy;
            end
            chk({tag, ".func"},  32'(risk_func), op ? 32'(f) : 32'd7);
            chk({tag, ".addr"},  32'(risk_addr), 32'(m_addr));
            chk({tag, ".reg"},   32'(risk_reg), 32'(m_reg));
            chk({tag, ".sx"},    32'(risk_stride_x), 32'(m_sx));
            chk({tag, ".sy"},    32'(risk_stride_y), 32'(m_sy));
            chk({tag, ".busy"},  32'(busy), 32'(c <= done_c));
            chk({tag, ".done"},  32'(done), 32'(c == done_c));
            chk({tag, ".err"},   32'(err), 32'((c == done_c) && err_exp));
            chk({tag, ".ready"}, 32'(cmd_if.cmd_ready), 32'(c > done_c));
            if (abort_c != 0 && c == abort_c) begin
                reset = 1'b1;
                scramble(1'b1);
                @(negedge clk);
                m_addr = '0; m_reg = '0; m_sx = '0; m_sy = '0;
                chk({tag, ".abort_func"},  32'(risk_func), 32'd7);
                chk({tag, ".abort_busy"},  32'(busy), 32'd0);
                chk({tag, ".abort_done"},  32'(done), 32'd0);
                chk({tag, ".abort_ready"}, 32'(cmd_if.cmd_ready), 32'd0);
                reset = 1'b0;
                cmd_if.cmd_valid = 1'b0;
                for (int k = 0; k < n_ops + DRAIN + 2; k++) begin
                    @(negedge clk);
                    chk({tag, ".post_func"},  32'(risk_func), 32'd7);
                    chk({tag, ".post_done"},  32'(done), 32'd0);
                    chk({tag, ".post_busy"},  32'(busy), 32'd0);
                    chk({tag, ".post_addr"},  32'(risk_addr), 32'd0);
                    chk({tag, ".post_ready"}, 32'(cmd_if.cmd_ready), 32'd1);
                end
                return;
            end
            // Inputs are don't-care while busy; never offer a descriptor on the idle cycle.
            scramble((c <= done_c) ? 1'($urandom) : 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [2:0] rf;
        logic [7:0] rc;
        reset = 1'b1;
        scramble(1'b0);
        m_addr = '0; m_reg = '0; m_sx = '0; m_sy = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.ready", 32'(cmd_if.cmd_ready), 32'd0);
        chk("rst.func",  32'(risk_func), 32'd7);
        chk("rst.addr",  32'(risk_addr), 32'd0);
        chk("rst.reg",   32'(risk_reg), 32'd0);
        chk("rst.sx",    32'(risk_stride_x), 32'd0);
        chk("rst.sy",    32'(risk_stride_y), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.err",   32'(err), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst.ready_after", 32'(cmd_if.cmd_ready), 32'd1);

        run_desc("basic",   3'b000, 5'd4,  15'd100,   14'd7,  14'd9,  15'd16, 8'd3, 0);
        run_desc("zero",    3'b001, 5'd2,  15'd55,    14'd1,  14'd2,  15'd3,  8'd0, 0);
        run_desc("badfunc", 3'b101, 5'd2,  15'd55,    14'd1,  14'd2,  15'd3,  8'd4, 0);
        run_desc("wrap",    3'b001, 5'd0,  15'd32760, 14'd3,  14'd4,  15'd8,  8'd2, 0);
        run_desc("regwrap", 3'b010, 5'd31, 15'd200,   14'd5,  14'd6,  15'd1,  8'd2, 0);
        run_desc("one",     3'b010, 5'd9,  15'd12345, 14'd11, 14'd12, 15'd0,  8'd1, 0);
        run_desc("abort",   3'b000, 5'd10, 15'd400,   14'd13, 14'd14, 15'd20, 8'd4, 3);

        for (int i = 0; i < 25; i++) begin
            rf = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rc = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            run_desc("rnd", rf, 5'($urandom), 15'($urandom), 14'($urandom), 14'($urandom),
                     15'($urandom), rc, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
